// File: rtl/ex_muldiv_hilo.sv
// Iterative shift-add multiplier / restoring divider that owns the HI/LO pair.
// Signed ops run on magnitudes; signs are applied in the FIX state.
module ex_muldiv_hilo #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] Rdata1,
  input  logic [WIDTH-1:0] Rdata2,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   acc_q, ql_q, b_q, hi_q, lo_q;
  logic               mul_q, neg_q, rem_neg_q, dz_q;
  logic               busy_q, done_q, divzero_q;

  logic               signed_op_s, a_neg_s, b_neg_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s, mul_add_s;
  logic [WIDTH:0]     mul_sum_s, div_sh_s, div_diff_s;
  logic [WIDTH-1:0]   acc_d, ql_d;
  logic [2*WIDTH-1:0] prod_s, prod_fix_s;
  logic [WIDTH-1:0]   quo_fix_s, rem_fix_s;

  // Operand sign/magnitude decode for the issuing instruction
  always_comb begin
    signed_op_s = (Op == OP_MULT) || (Op == OP_DIV);
    a_neg_s     = signed_op_s && Rdata1[WIDTH-1];
    b_neg_s     = signed_op_s && Rdata2[WIDTH-1];
    a_mag_s     = a_neg_s ? -Rdata1 : Rdata1;
    b_mag_s     = b_neg_s ? -Rdata2 : Rdata2;
  end

  // One multiply or divide iteration on the accumulator pair
  always_comb begin
    acc_d      = acc_q;
    ql_d       = ql_q;
    mul_add_s  = ql_q[0] ? b_q : '0;
    mul_sum_s  = {1'b0, acc_q} + {1'b0, mul_add_s};
    div_sh_s   = {acc_q, ql_q[WIDTH-1]};
    // Bit WIDTH of the difference is the borrow since the shifted value is below 2*divisor
    div_diff_s = div_sh_s - {1'b0, b_q};
    if (mul_q) begin
      acc_d = mul_sum_s[WIDTH:1];
      ql_d  = {mul_sum_s[0], ql_q[WIDTH-1:1]};
    end else if (!div_diff_s[WIDTH]) begin
      acc_d = div_diff_s[WIDTH-1:0];
      ql_d  = {ql_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_d = div_sh_s[WIDTH-1:0];
      ql_d  = {ql_q[WIDTH-2:0], 1'b0};
    end
  end

  // Sign correction of the finished magnitudes
  always_comb begin
    prod_s     = {acc_q, ql_q};
    prod_fix_s = neg_q ? -prod_s : prod_s;
    quo_fix_s  = neg_q ? -ql_q : ql_q;
    rem_fix_s  = rem_neg_q ? -acc_q : acc_q;
  end

  // Control FSM, datapath registers and HI/LO
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      ql_q      <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      mul_q     <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (Start && !Flush) begin
            case (Op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                acc_q     <= '0;
                ql_q      <= a_mag_s;
                b_q       <= b_mag_s;
                neg_q     <= a_neg_s ^ b_neg_s;
                rem_neg_q <= a_neg_s;
                mul_q     <= (Op == OP_MULT) || (Op == OP_MULTU);
                busy_q    <= 1'b1;
                if (!((Op == OP_MULT) || (Op == OP_MULTU)) && (Rdata2 == '0)) begin
                  dz_q    <= 1'b1;
                  state_q <= S_FIX;
                end else begin
                  dz_q    <= 1'b0;
                  cnt_q   <= CNT_W'(WIDTH);
                  state_q <= S_RUN;
                end
              end
              OP_MTHI: hi_q <= Rdata1;
              OP_MTLO: lo_q <= Rdata1;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          if (Flush) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            acc_q <= acc_d;
            ql_q  <= ql_d;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_q <= S_FIX;
          end
        end
        S_FIX: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          if (!Flush) begin
            done_q <= 1'b1;
            if (dz_q) begin
              divzero_q <= 1'b1;
            end else if (mul_q) begin
              {hi_q, lo_q} <= prod_fix_s;
            end else begin
              hi_q <= rem_fix_s;
              lo_q <= quo_fix_s;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy    = busy_q;
  assign Done    = done_q;
  assign DivZero = divzero_q;
  assign HI      = hi_q;
  assign LO      = lo_q;

endmodule

// File: tb/tb_ex_muldiv_hilo.sv
// Bench for ex_muldiv_hilo: WIDTH=32 vector table, random model vectors with a
// result scoreboard, hand-written flush/reset/ignore sequences, and a WIDTH=8 instance.
module tb_ex_muldiv_hilo;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start, flush, busy, done, divzero;
  logic [2:0]  op;
  logic [31:0] rd1, rd2, hi, lo;
  logic        s8_start, busy8, done8, dz8;
  logic [2:0]  s8_op;
  logic [7:0]  s8_a, s8_b, hi8, lo8;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, ehi, elo;
    logic        edz;
    int          ebusy;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  always #5 CLK = ~CLK;

  ex_muldiv_hilo #(.WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .Start(start), .Op(op), .Rdata1(rd1), .Rdata2(rd2),
    .Flush(flush), .Busy(busy), .Done(done), .DivZero(divzero), .HI(hi), .LO(lo)
  );

  ex_muldiv_hilo #(.WIDTH(8)) dut8 (
    .CLK(CLK), .RST(RST), .Start(s8_start), .Op(s8_op), .Rdata1(s8_a), .Rdata2(s8_b),
    .Flush(1'b0), .Busy(busy8), .Done(done8), .DivZero(dz8), .HI(hi8), .LO(lo8)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] ehi, input logic [31:0] elo,
                              input logic edz, input int ebusy);
    vec_t v;
    v.op = o; v.a = a; v.b = b; v.ehi = ehi; v.elo = elo; v.edz = edz; v.ebusy = ebusy;
    return v;
  endfunction

  // Behavioural reference built on 64-bit language arithmetic
  function automatic vec_t model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    vec_t v;
    longint sa, sb_, q, r;
    logic [63:0] p;
    v = mk(o, a, b, 32'h0, 32'h0, 1'b0, 33);
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    case (o)
      3'd0: begin p = 64'(sa * sb_); v.ehi = p[63:32]; v.elo = p[31:0]; end
      3'd1: begin p = {32'h0, a} * {32'h0, b}; v.ehi = p[63:32]; v.elo = p[31:0]; end
      3'd2: begin q = sa / sb_; r = sa % sb_; v.elo = q[31:0]; v.ehi = r[31:0]; end
      default: begin v.elo = a / b; v.ehi = a % b; end
    endcase
    return v;
  endfunction

  // Issue one op at the current negedge, follow Busy, compare on Done.
  // intrude > 0 pulses an MTHI Start during that Busy cycle.
  task automatic run_vec(input vec_t v, input int intrude, input string nm);
    int   nb;
    logic seen, stop, early;
    vec_t e;
    start = 1'b1; op = v.op; rd1 = v.a; rd2 = v.b;
    sb.push_back(v);
    @(posedge CLK); #1;
    start = 1'b0; op = 3'd6; rd1 = $urandom; rd2 = $urandom;
    nb = 0; seen = 1'b0; stop = 1'b0; early = 1'b0;
    for (int c = 0; c < 200 && !seen && !stop; c++) begin
      @(negedge CLK);
      if (start) begin start = 1'b0; op = 3'd6; end
      if (busy) begin
        nb++;
        if (done) early = 1'b1;
        if (nb == intrude) begin start = 1'b1; op = 3'd4; rd1 = 32'hDEADBEEF; end
      end else if (done) begin
        seen = 1'b1;
      end else begin
        stop = 1'b1;
      end
    end
    e = sb.pop_front();
    chk({nm, "_done"}, seen, 1'b1);
    chk({nm, "_busy_cycles"}, nb, e.ebusy);
    chk({nm, "_done_during_busy"}, early, 1'b0);
    if (seen) begin
      chk({nm, "_hi"}, hi, e.ehi);
      chk({nm, "_lo"}, lo, e.elo);
      chk({nm, "_divzero"}, divzero, e.edz);
    end
  endtask

  task automatic mt(input logic [2:0] o, input logic [31:0] val, input string nm);
    start = 1'b1; op = o; rd1 = val;
    @(posedge CLK); #1;
    start = 1'b0; op = 3'd6;
    @(negedge CLK);
    chk({nm, "_val"}, (o == 3'd4) ? hi : lo, val);
    chk({nm, "_nobusy"}, {busy, done}, 2'b00);
  endtask

  task automatic run8(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] ehi, input logic [7:0] elo, input string nm);
    int   nb;
    logic seen, stop;
    s8_start = 1'b1; s8_op = o; s8_a = a; s8_b = b;
    @(posedge CLK); #1;
    s8_start = 1'b0; s8_op = 3'd6;
    nb = 0; seen = 1'b0; stop = 1'b0;
    for (int c = 0; c < 50 && !seen && !stop; c++) begin
      @(negedge CLK);
      if (busy8) nb++;
      else if (done8) seen = 1'b1;
      else stop = 1'b1;
    end
    chk({nm, "_done"}, seen, 1'b1);
    chk({nm, "_busy_cycles"}, nb, 9);
    chk({nm, "_hi"}, hi8, ehi);
    chk({nm, "_lo"}, lo8, elo);
  endtask

  initial begin
    logic        any_done;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    RST = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd6; rd1 = '0; rd2 = '0;
    s8_start = 1'b0; s8_op = 3'd6; s8_a = '0; s8_b = '0;

    tbl.push_back(mk(3'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 33));
    tbl.push_back(mk(3'd1, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 1'b0, 33));
    tbl.push_back(mk(3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33));
    tbl.push_back(mk(3'd3, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33));
    tbl.push_back(mk(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33));
    tbl.push_back(mk(3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33));
    tbl.push_back(mk(3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33));
    tbl.push_back(mk(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33));
    tbl.push_back(mk(3'd3, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 1'b0, 33));
    tbl.push_back(mk(3'd2, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0, 33));
    tbl.push_back(mk(3'd3, 32'd5,        32'd9,        32'd5,        32'd0,        1'b0, 33));

    #2;
    chk("reset_async", {hi, lo, busy, done, divzero}, '0);
    @(negedge CLK);
    chk("reset_held", {hi, lo, hi8, lo8, busy, done, divzero, busy8}, '0);
    RST = 1'b0;
    @(negedge CLK);

    // Back-to-back: each op issues in the Done cycle of the previous one
    foreach (tbl[i]) run_vec(tbl[i], 0, $sformatf("tbl%0d", i));
    for (int i = 0; i < 8; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 28);
      if (ro >= 3'd2 && rb == 32'h0) rb = 32'd1;
      run_vec(model(ro, ra, rb), 0, $sformatf("rnd%0d", i));
    end

    mt(3'd4, 32'h11, "mthi");
    mt(3'd5, 32'h22, "mtlo");
    run_vec(mk(3'd3, 32'd7, 32'd0, 32'h11, 32'h22, 1'b1, 1), 0, "divu_by_zero");

    // Flush at iteration 10: no Done, HI/LO untouched
    start = 1'b1; op = 3'd0; rd1 = 32'd3; rd2 = 32'd5;
    @(posedge CLK); #1; start = 1'b0; op = 3'd6;
    repeat (10) @(negedge CLK);
    flush = 1'b1;
    @(posedge CLK); #1; flush = 1'b0;
    @(negedge CLK);
    chk("flush_busy_drop", busy, 1'b0);
    any_done = 1'b0;
    repeat (40) begin @(negedge CLK); any_done |= done; end
    chk("flush_no_done", any_done, 1'b0);
    chk("flush_hilo", {hi, lo}, {32'h11, 32'h22});

    // Flush and Start together in IDLE: Start dropped
    start = 1'b1; op = 3'd4; rd1 = 32'h99; flush = 1'b1;
    @(posedge CLK); #1; start = 1'b0; flush = 1'b0; op = 3'd6;
    @(negedge CLK);
    chk("flush_start_idle", {busy, hi}, {1'b0, 32'h11});

    // Start while Busy ignored, including MTHI
    run_vec(mk(3'd3, 32'd9, 32'd0, 32'h11, 32'h22, 1'b1, 1), 1, "ignore_in_fix");
    run_vec(mk(3'd1, 32'd2, 32'd3, 32'h0, 32'h6, 1'b0, 33), 5, "ignore_in_run");
    @(negedge CLK);
    chk("ignore_hi_kept", hi, 32'h0);

    // Asynchronous reset mid-run
    mt(3'd4, 32'h55, "mthi2");
    start = 1'b1; op = 3'd0; rd1 = 32'd3; rd2 = 32'd5;
    @(posedge CLK); #1; start = 1'b0; op = 3'd6;
    repeat (5) @(negedge CLK);
    #3 RST = 1'b1;
    #1;
    chk("async_rst_mid_run", {hi, lo, busy}, '0);
    @(negedge CLK); RST = 1'b0;
    any_done = 1'b0;
    repeat (40) begin @(negedge CLK); any_done |= done; end
    chk("rst_no_done", any_done, 1'b0);

    run8(3'd0, 8'h80, 8'h80, 8'h40, 8'h00, "w8_mult");
    run8(3'd2, 8'h81, 8'h03, 8'hFF, 8'hD6, "w8_div");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_hilo.md
# ex_muldiv_hilo

Parametrised, multi-cycle multiply/divide unit that owns the HI/LO register pair for the EX stage of the MIPS datapath. It replaces single-cycle `*`, `/` and `%` with an iterative shift-add multiplier and a restoring divider, and reports progress through a Start/Busy/Done handshake. The surrounding stage stalls MFHI/MFLO, and any new mul/div, while Busy is high.

## Interface
Parameters:
- WIDTH, 32, operand/HI/LO width (≥4); product is 2*WIDTH bits
- CNT_W, $clog2(WIDTH+1), iteration counter width

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- Start  in  1  request; sampled on CLK rising edge
- Op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
- Rdata1  in  WIDTH  rs operand (multiplicand / dividend / MTHI/MTLO source)
- Rdata2  in  WIDTH  rt operand (multiplier / divisor)
- Flush  in  1  abort in-flight operation (pipeline flush)
- Busy  out  1  operation in flight; HI/LO not valid for MFHI/MFLO
- Done  out  1  one-cycle pulse; HI/LO hold the new result this cycle
- DivZero  out  1  one-cycle pulse with Done for DIV/DIVU with divisor 0
- HI  out  WIDTH  HI register
- LO  out  WIDTH  LO register

## Operation
- FSM states:
  - IDLE
  - RUN: WIDTH iterations, counter counts down
  - FIX: sign correction and HI/LO write
- IDLE transitions on Start & !Flush:
  - Op 0–3 with nonzero divisor (or any mul): latch operand magnitudes and result-sign flags, go to RUN.
  - Op 2/3 with Rdata2==0: go directly to FIX with a div-zero flag.
  - Op 4/5: write HI/LO = Rdata1 at that edge; stay IDLE; no Busy, no Done.
  - Op 6/7: ignored.
- Signed ops (MULT, DIV) operate on magnitudes:
  - Product is negated if operand signs differ.
  - Quotient is negated if signs differ and truncates toward zero.
  - Remainder takes the sign of the dividend.
  - Most-negative / −1 gives LO=most-negative, HI=0 (no trap).
- MULT/MULTU: {HI,LO} = full 2*WIDTH-bit product.
- DIV/DIVU: LO = quotient, HI = remainder.
- Divide by zero: HI/LO unchanged; Done and DivZero pulse together.
- Start while Busy is ignored (no queueing), including MTHI/MTLO.
- Flush while Busy: return to IDLE at the next edge; HI/LO unchanged; no Done.
- Flush and Start in the same IDLE cycle: Flush wins and Start is dropped.

## Timing
- Reset values (asynchronous, immediate): state IDLE, HI=0, LO=0, Busy=0, Done=0, DivZero=0, counter=0.
- Mul/div with Start sampled at edge E:
  - Busy=1 from E through edge E+WIDTH+1, i.e. WIDTH+1 cycles.
  - Edge E+WIDTH+1 writes HI/LO and returns to IDLE.
  - Done=1 in the cycle after E+WIDTH+1, with Busy=0.
- Divide by zero: Busy=1 for 1 cycle; Done and DivZero follow at edge E+1.
- A new Start is accepted in the Done cycle, so back-to-back issue costs WIDTH+2 cycles per op.
- MTHI/MTLO: zero latency; HI/LO show the new value in the cycle after the sampling edge.
- Done and DivZero are registered outputs and never high for more than 1 cycle.
- RST asserted mid-RUN: immediate IDLE, HI/LO cleared, no Done.
- Rdata1/Rdata2/Op only need to be valid in the Start cycle; they are latched internally.

## Test plan
- Reset, then MULT Rdata1=0xFFFFFFFE, Rdata2=3 (WIDTH=32):
  - Busy 33 cycles.
  - Done at cycle 34 with HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - MULTU with the same operands gives HI=0x00000002, LO=0xFFFFFFFA.
- DIV Rdata1=0xFFFFFFF9 (−7), Rdata2=2:
  - LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 100/7 gives LO=14, HI=2.
- DIV 0x80000000 / 0xFFFFFFFF:
  - LO=0x80000000, HI=0, DivZero=0.
- DIVU 7/0 with HI=0x11, LO=0x22 preloaded via MTHI/MTLO:
  - Busy for 1 cycle.
  - Done=DivZero=1.
  - HI=0x11, LO=0x22 unchanged.
- MULT started, Flush at iteration 10:
  - Busy drops next cycle; no Done; HI/LO keep prior values.
  - A Start issued at iteration 5 of a second op is ignored.
  - Asynchronous RST mid-RUN clears HI/LO without waiting for a clock edge.
- Parametric run with WIDTH=8:
  - MULT 0x80*0x80 gives {HI,LO}=0x4000.
  - DIV 0x81/0x03 gives LO=0xD6, HI=0xFF.
  - Latency is 9 Busy cycles.
